// File: rtl/adc_fifo_pkg.sv
// Shared constants and trigger-FSM state encoding for the ADC sample FIFO.
package adc_fifo_pkg;

  localparam int SMPL_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } trig_state_t;

endpackage

// File: rtl/adc_fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module adc_fifo_ram #(
  parameter int ADDR_W = 9,
  parameter int WIDTH  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write on a shared address keeps a full-FIFO read+write coherent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_sample_fifo.sv
// ADC sample FIFO with DMA burst trigger; rd_data_o valid 1 cycle after accepted rd_i, samples dropped (sticky overflow) when full.
// ADC_FIFO_OVF_TAG_EN: tag the first sample accepted after a drop with rd_data_o[15].
module adc_sample_fifo
  import adc_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int BURST_LEN  = 128,
  parameter int DATA_W     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic [SMPL_W-1:0]     smpl_data_i,
  input  logic                  smpl_vld_i,
  input  logic                  rd_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic                  trig_o,
  input  logic                  dma_done_i,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overflow_o
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   BURST_CNT = (DEPTH_LOG2+1)'(BURST_LEN);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
`ifdef ADC_FIFO_OVF_TAG_EN
  localparam int MEM_W = SMPL_W + 1;
`else
  localparam int MEM_W = SMPL_W;
`endif

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level, pop_cnt, pop_cnt_nxt;
  logic                  ovf;
  logic                  wr, rd_acc, drop;
  logic [MEM_W-1:0]      mem_wdata, mem_rdata;
  trig_state_t           state, state_nxt;
  logic                  trig;

  assign empty_o    = (level == '0);
  assign full_o     = (level == LVL_FULL);
  assign level_o    = level;
  assign overflow_o = ovf;
  assign trig_o     = trig;

  assign rd_acc = rd_i & ~empty_o;
  assign wr     = enable_i & smpl_vld_i & (~full_o | rd_acc);
  assign drop   = enable_i & smpl_vld_i & full_o & ~rd_acc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr)     wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr && !rd_acc)      level <= level + LVL_ONE;
      else if (!wr && rd_acc) level <= level - LVL_ONE;
      if (drop) ovf <= 1'b1;
    end
  end

`ifdef ADC_FIFO_OVF_TAG_EN
  logic tag_pend;

  // Armed by a drop, consumed by the next accepted sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        tag_pend <= 1'b0;
    else if (flush_i) tag_pend <= 1'b0;
    else if (drop)    tag_pend <= 1'b1;
    else if (wr)      tag_pend <= 1'b0;
  end

  assign mem_wdata = {tag_pend, smpl_data_i};

  always_comb begin
    rd_data_o               = '0;
    rd_data_o[SMPL_W-1:0]   = mem_rdata[SMPL_W-1:0];
    rd_data_o[15]           = mem_rdata[SMPL_W];
  end
`else
  assign mem_wdata = smpl_data_i;

  always_comb begin
    rd_data_o             = '0;
    rd_data_o[SMPL_W-1:0] = mem_rdata;
  end
`endif

  // Flush suppresses both ports so rd_data_o holds across it.
  adc_fifo_ram #(
    .ADDR_W (DEPTH_LOG2),
    .WIDTH  (MEM_W)
  ) u_ram (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (wr & ~flush_i),
    .waddr (wr_ptr),
    .wdata (mem_wdata),
    .re    (rd_acc & ~flush_i),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      pop_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pop_cnt <= pop_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pop_cnt_nxt = pop_cnt;
    trig        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (level >= BURST_CNT) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        trig        = 1'b1;
        pop_cnt_nxt = '0;
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        pop_cnt_nxt = pop_cnt + {{DEPTH_LOG2{1'b0}}, rd_acc};
        if (pop_cnt_nxt == BURST_CNT || dma_done_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush_i) begin
      state_nxt   = ST_IDLE;
      pop_cnt_nxt = '0;
      trig        = 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed self-checking bench for adc_sample_fifo (default parameters).
module tb_adc_sample_fifo;

  logic        clk = 1'b0;
  logic        rst, enable, flush, vld, rd, dma_done;
  logic [11:0] sdat;
  logic [15:0] rd_data;
  logic        trig, empty, full, ovf;
  logic [9:0]  level;

  adc_sample_fifo dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .flush_i     (flush),
    .smpl_data_i (sdat),
    .smpl_vld_i  (vld),
    .rd_i        (rd),
    .rd_data_o   (rd_data),
    .trig_o      (trig),
    .dma_done_i  (dma_done),
    .level_o     (level),
    .empty_o     (empty),
    .full_o      (full),
    .overflow_o  (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int trig_cnt = 0;
  int trig_cyc = -1;
  always @(negedge clk) begin
    if (trig) begin
      trig_cnt++;
      trig_cyc = cyc;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [15:0] q[$];
  logic [11:0] sv = 12'h001;
  logic        pend = 1'b0;
  logic [15:0] last_rd = '0;
  int          mark, base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word(input logic [11:0] s, input logic tag);
    logic [15:0] w;
    w = {4'b0, s};
`ifdef ADC_FIFO_OVF_TAG_EN
    w[15] = tag;
`endif
    return w;
  endfunction

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      sdat = sv;
      vld  = 1'b1;
      tick();
      if (enable) begin
        if (q.size() < 512) begin
          q.push_back(word(sv, pend));
          pend = 1'b0;
        end else begin
          pend = 1'b1;
        end
      end
      sv = sv + 12'd7;
    end
    vld = 1'b0;
  endtask

  task automatic pop_chk(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      rd = 1'b1;
      tick();
      if (q.size() > 0) last_rd = q.pop_front();
      chk(tag, rd_data, last_rd);
    end
    rd = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; flush = 1'b0; vld = 1'b0;
    rd = 1'b0; dma_done = 1'b0; sdat = '0;
    repeat (3) tick();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_trig", trig, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick();

    // Disabled capture ignores strobes
    push(1);
    chk("enable_low_level", level, 0);
    enable = 1'b1;

    // 1. Trigger threshold
    push(127);
    repeat (2) tick();
    chk("no_trig_127", trig_cnt, 0);
    chk("level_127", level, 127);
    push(1);
    mark = cyc;
    repeat (4) tick();
    chk("trig_once", trig_cnt, 1);
    chk("trig_cycle", trig_cyc, mark + 1);

    // 2. Burst drain with backlog
    push(172);
    chk("level_300", level, 300);
    chk("no_trig_in_wait", trig_cnt, 1);
    pop_chk(128, "burst_data");
    mark = cyc;
    repeat (4) tick();
    chk("retrig_cnt", trig_cnt, 2);
    chk("retrig_cycle", trig_cyc, mark + 1);
    chk("level_172", level, 172);
    pop_chk(172, "drain_data");
    repeat (3) tick();
    chk("no_trig_below", trig_cnt, 2);
    chk("drained_empty", empty, 1);

    // 3. Overflow
    push(515);
    chk("ovf_full", full, 1);
    chk("ovf_level", level, 512);
    chk("ovf_flag", ovf, 1);
    pop_chk(1, "ovf_pop");
    push(1);
    chk("ovf_refull", level, 512);
    pop_chk(512, "ovf_drain");
`ifdef ADC_FIFO_OVF_TAG_EN
    chk("ovf_tag_bit", rd_data[15], 1);
`else
    chk("no_tag_bit", rd_data[15], 0);
`endif
    chk("ovf_sticky", ovf, 1);

    // 4. Full with simultaneous read and write
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    pend = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_ovf", ovf, 0);
    chk("flush_empty", empty, 1);
    push(512);
    chk("fill_full", full, 1);
    sdat = sv; vld = 1'b1; rd = 1'b1;
    tick();
    vld = 1'b0; rd = 1'b0;
    last_rd = q.pop_front();
    q.push_back(word(sv, 1'b0));
    sv = sv + 12'd7;
    chk("rw_full_level", level, 512);
    chk("rw_full_ovf", ovf, 0);
    chk("rw_full_data", rd_data, last_rd);

    // 5. Empty pop and streaming across pointer wrap
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    chk("flush_keeps_rd", rd_data, last_rd);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("empty_pop_level", level, 0);
    chk("empty_pop_flag", empty, 1);
    chk("empty_pop_data", rd_data, last_rd);
    for (int i = 0; i < 1000; i++) begin
      sdat = sv; vld = 1'b1; rd = (i > 0);
      tick();
      if (i > 0) begin
        last_rd = q.pop_front();
        chk("stream_data", rd_data, last_rd);
      end
      q.push_back(word(sv, 1'b0));
      sv = sv + 12'd7;
    end
    vld = 1'b0; rd = 1'b0;
    pop_chk(1, "stream_tail");
    chk("stream_empty", empty, 1);

    // 6. Flush mid-burst, then dma_done exit
    base = trig_cnt;
    push(128);
    repeat (3) tick();
    chk("mid_trig", trig_cnt, base + 1);
    pop_chk(88, "mid_pop");
    chk("mid_level_40", level, 40);
    flush = 1'b1; rd = 1'b1; vld = 1'b1; sdat = sv;
    tick();
    flush = 1'b0; rd = 1'b0; vld = 1'b0;
    q.delete();
    chk("mid_flush_level", level, 0);
    chk("mid_flush_empty", empty, 1);
    chk("mid_flush_rd", rd_data, last_rd);
    repeat (4) tick();
    chk("mid_flush_no_trig", trig_cnt, base + 1);
    push(128);
    mark = cyc;
    repeat (3) tick();
    chk("post_flush_trig", trig_cnt, base + 2);
    chk("post_flush_cycle", trig_cyc, mark + 1);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    mark = cyc;
    repeat (4) tick();
    chk("dma_done_trig", trig_cnt, base + 3);
    chk("dma_done_cycle", trig_cyc, mark + 1);

    // Asynchronous reset while a write is in flight
    sdat = sv; vld = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_level", level, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_trig", trig, 0);
    chk("arst_rd_data", rd_data, 0);
    vld = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
